// File: rtl/bcd_seq_converter_if.sv
// Valid/ready operand and result bundle for bcd_seq_converter.
// master = producer/consumer side, slave = converter side.
interface bcd_seq_converter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIGITS = 3
) ();
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_W-1:0]     i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_ovf;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_bcd, o_ovf
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_bcd, o_ovf
  );
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock
// through a single row of add-3 correctors.
// Optional feature: define BCD_OVF_EN to build the sticky overflow flag;
// otherwise o_ovf is tied low and o_bcd holds operand mod 10^DIGITS.
module bcd_seq_converter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  bcd_seq_converter_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_last;
  logic               r_ready;
  logic               r_valid;
  logic [DATA_W-1:0]  r_bin;
  logic [BCD_W-1:0]   r_work;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_shift;

  // Add-3 row: every digit >= 5 is corrected in parallel before the shift
  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_work[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
      end
    end
  end

  // Top bit of the corrected field falls off; binary MSB enters digit 0
  assign w_shift = {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};

  // Next-state decode
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_valid && r_ready) begin
          w_accept = 1'b1;
          w_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_last = 1'b1;
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.i_ready && r_valid) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register with registered handshake outputs decoded from next state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      r_valid <= (w_next == ST_DONE);
    end
  end

  // Shift datapath: load on accept, one double-dabble step per SHIFT cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin  <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
    end else if (w_accept) begin
      r_bin  <= bus.i_data;
      r_work <= '0;
      r_cnt  <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_bin  <= r_bin << 1;
      r_work <= w_shift;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_bcd <= w_shift;
      end
    end
  end

`ifdef BCD_OVF_EN
  logic r_acc;
  logic r_ovf;
  logic w_top_out;

  assign w_top_out = w_adj[BCD_W-1];

  // Sticky overflow: any bit lost off the top digit, or an out-of-range top digit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_acc <= r_acc | w_top_out;
      if (w_last) begin
        r_ovf <= r_acc | w_top_out | (w_shift[BCD_W-1 -: 4] >= 4'd10);
      end
    end
  end

  assign bus.o_ovf = r_ovf;
`else
  assign bus.o_ovf = 1'b0;
`endif

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_bcd   = r_bcd;

endmodule
